// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction fetch stage.
//   - RESET_PC_DEFAULT : default PC of the first fetch after reset
//   - OPCODE_W / opcode_t / OPCODE_* : 7-bit major opcode field of inst[6:0]
//   - fetch_state_e : fetch FSM states (HALT exists only when
//     FETCH_MISALIGN_TRAP_EN is defined)
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int unsigned OPCODE_W = 7;
    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OPCODE_LOAD   = 7'b000_0011;
    localparam opcode_t OPCODE_OP_IMM = 7'b001_0011;
    localparam opcode_t OPCODE_AUIPC  = 7'b001_0111;
    localparam opcode_t OPCODE_STORE  = 7'b010_0011;
    localparam opcode_t OPCODE_OP     = 7'b011_0011;
    localparam opcode_t OPCODE_LUI    = 7'b011_0111;
    localparam opcode_t OPCODE_BRANCH = 7'b110_0011;
    localparam opcode_t OPCODE_JALR   = 7'b110_0111;
    localparam opcode_t OPCODE_JAL    = 7'b110_1111;
    localparam opcode_t OPCODE_SYSTEM = 7'b111_0011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        HALT  = 2'd3
`endif
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous DEPTH-entry FIFO of {pc, inst}.
//   clk, rst          : clock, synchronous active-high reset
//   clear             : drop all entries (takes priority over push/pop)
//   push/push_pc/push_inst : write one entry at the tail
//   pop               : remove the head entry (caller guarantees non-empty)
//   head_pc/head_inst : head entry fields (undefined while empty)
//   count             : number of valid entries, 0..DEPTH
module fetch_buffer #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic [31:0]            push_pc,
    input  logic [31:0]            push_inst,
    input  logic                   pop,
    output logic [31:0]            head_pc,
    output logic [31:0]            head_inst,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign head_pc   = pc_mem[rd_ptr];
    assign head_inst = inst_mem[rd_ptr];
    assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, issues in-order word
// requests to instruction memory, buffers up to DEPTH returned instructions
// and hands them to decode; redirects flush buffered and in-flight fetches.
//   clk, rst                      : clock, synchronous active-high reset
//   imem_req_valid/addr/ready     : fetch request channel
//   imem_rsp_valid/data           : in-order response channel
//   redirect, redirect_pc         : taken branch/jump target from execute
//   inst_valid/ready, inst, inst_pc, opcode : decode handshake
//   fetch_misalign                : misaligned-redirect trap flag (only when
//                                   FETCH_MISALIGN_TRAP_EN is defined)
// Build option FETCH_MISALIGN_TRAP_EN: misaligned redirects enter HALT
// instead of being word-aligned.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    output logic [31:0]         imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [31:0]         inst,
    output logic [31:0]         inst_pc,
    output logic [OPCODE_W-1:0] opcode
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                fetch_misalign
`endif
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] in_flight_q, in_flight_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] buf_count;
    logic [CW:0]   credit_used;
    logic [31:0]   head_pc, head_inst;
    logic [31:0]   rsp_pc;
    logic [31:0]   target;
    logic          req_fire, pop, push, clear, redirect_ok;

    assign target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_ok    = redirect && (state_q != HALT);
    assign fetch_misalign = (state_q == HALT);
`else
    assign redirect_ok    = redirect;
`endif

    assign inst_valid = (buf_count != '0);
    assign pop        = inst_valid && inst_ready;

    // A same-cycle pop frees its slot for this cycle's request; this keeps
    // one instruction per cycle with DEPTH = latency + 1.
    assign credit_used    = {1'b0, in_flight_q} + {1'b0, buf_count} - {{CW{1'b0}}, pop};
    assign imem_req_valid = (state_q == RUN) && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Requests since the last redirect are contiguous, so the oldest
    // outstanding one sits in_flight words behind pc_q.
    assign rsp_pc = pc_q - (32'(in_flight_q) << 2);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        in_flight_d = in_flight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_cnt_d  = drop_cnt_q;
        push        = 1'b0;
        clear       = 1'b0;

        case (state_q)
            IDLE:  state_d = RUN;
            RUN: begin
                if (req_fire) pc_d = pc_q + 32'd4;
                push = imem_rsp_valid;
            end
            FLUSH: begin
                if (imem_rsp_valid) begin
                    drop_cnt_d = drop_cnt_q - 1'b1;
                    if (drop_cnt_q == CW'(1)) state_d = RUN;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            HALT:  state_d = HALT;
`endif
            default: state_d = IDLE;
        endcase

        if (redirect_ok) begin
            pc_d       = target;
            clear      = 1'b1;
            push       = 1'b0;
            drop_cnt_d = in_flight_d;
            state_d    = (in_flight_d != '0) ? FLUSH : RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) state_d = HALT;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            in_flight_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            in_flight_q <= in_flight_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    fetch_buffer #(
        .DEPTH(DEPTH)
    ) u_fetch_buffer (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .push     (push),
        .push_pc  (rsp_pc),
        .push_inst(imem_rsp_data),
        .pop      (pop),
        .head_pc  (head_pc),
        .head_inst(head_inst),
        .count    (buf_count)
    );

    assign inst    = inst_valid ? head_inst : '0;
    assign inst_pc = inst_valid ? head_pc   : '0;
    assign opcode  = inst[OPCODE_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;

    localparam int unsigned PH_BRINGUP = 1;
    localparam int unsigned PH_STALL   = 2;
    localparam int unsigned PH_REDIR   = 3;
    localparam int unsigned PH_SAME    = 4;
    localparam int unsigned PH_WRAP    = 5;
    localparam int unsigned PH_RAND    = 6;
    localparam int unsigned PH_MISAL   = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect       = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        inst_valid;
    logic        inst_ready     = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .opcode        (opcode)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misalign(fetch_misalign)
`endif
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    endfunction

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned phase    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_pc  = RESET_PC;
    logic        halted    = 1'b0;
    logic        prev_redir = 1'b0;
    int unsigned since     = 0;
    int unsigned rst_cnt   = 0;
    int unsigned acc_cnt   = 0;

    always @(negedge clk) begin
        exp_t       e;
        logic [6:0] op_exp;
        if (rst) begin
            exp_q.delete();
            model_pc   = RESET_PC;
            halted     = 1'b0;
            prev_redir = 1'b0;
            since      = 0;
            acc_cnt    = 0;
            if (rst_cnt == 1) begin
                check("rst_req_valid", imem_req_valid, 0);
                check("rst_req_addr", imem_req_addr, RESET_PC);
                check("rst_inst_valid", inst_valid, 0);
                check("rst_inst", inst, 0);
                check("rst_inst_pc", inst_pc, 0);
                check("rst_opcode", opcode, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
                check("rst_misalign", fetch_misalign, 0);
`endif
            end
            rst_cnt++;
        end else begin
            rst_cnt = 0;
            since++;

            if (prev_redir) check("inst_valid_after_redirect", inst_valid, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
            if (halted) begin
                check("halt_req_valid", imem_req_valid, 0);
                check("halt_misalign", fetch_misalign, 1);
                check("halt_inst_valid", inst_valid, 0);
            end
`endif
            case (phase)
                PH_BRINGUP: begin
                    if (since == 1) check("idle_no_req", imem_req_valid, 0);
                    if (since == 2) check("first_req_cycle", imem_req_valid, 1);
                    if (since == 3) check("no_early_inst", inst_valid, 0);
                    if (since == 4) begin
                        check("first_inst_valid", inst_valid, 1);
                        check("first_inst_pc", inst_pc, RESET_PC);
                    end
                    if (since >= 5 && since <= 15) check("throughput_inst_valid", inst_valid, 1);
                end
                PH_STALL: begin
                    if (since == 12) begin
                        check("stall_accepts", acc_cnt, 2);
                        check("stall_req_valid", imem_req_valid, 0);
                    end
                end
                PH_REDIR, PH_MISAL: begin
                    if (since == 5 || since == 6) check("flush_no_req", imem_req_valid, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (since == 7 && phase == PH_MISAL) check("halt_no_req", imem_req_valid, 0);
                    if (since == 7 && phase == PH_REDIR) check("refetch_req", imem_req_valid, 1);
`else
                    if (since == 7) check("refetch_req", imem_req_valid, 1);
`endif
                end
                PH_SAME: begin
                    if (since == 4) check("same_cycle_setup", {inst_valid, inst_ready, imem_rsp_valid, redirect}, 4'hF);
                    if (since == 5) check("same_flush_no_req", imem_req_valid, 0);
                    if (since == 6) check("same_refetch_req", imem_req_valid, 1);
                end
                PH_WRAP: begin
                    if (since == 8) begin
                        check("wrap_req_valid", imem_req_valid, 1);
                        check("wrap_req_addr", imem_req_addr, 32'h0000_0000);
                    end
                end
                default: ;
            endcase

            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL inst_unexpected: got pc %h with nothing expected (t=%0t)", inst_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    op_exp = e.data[6:0];
                    check("inst_pc", inst_pc, e.pc);
                    check("inst", inst, e.data);
                    check("opcode", opcode, op_exp);
                end
            end

            if (imem_req_valid && imem_req_ready) begin
                acc_cnt++;
                check("req_addr", imem_req_addr, model_pc);
                if (!redirect) exp_q.push_back('{model_pc, mem_word(model_pc)});
                model_pc = model_pc + 32'd4;
            end

            if (redirect && !halted) begin
                exp_q.delete();
                model_pc = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (redirect_pc[1:0] != 2'b00) halted = 1'b1;
`endif
            end
            prev_redir = redirect;
        end
    end

    // ---------------- stimulus + memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    pend_t       pend[$];
    int unsigned c        = 0;
    int unsigned last_due = 0;
    int unsigned lat_min  = 1;
    int unsigned lat_max  = 1;
    int unsigned p_ready  = 100;
    int unsigned p_inst   = 100;
    int unsigned p_redir  = 0;

    task automatic set_mode(input int unsigned lmin, input int unsigned lmax,
                            input int unsigned pr, input int unsigned pi, input int unsigned pd);
        lat_min = lmin; lat_max = lmax; p_ready = pr; p_inst = pi; p_redir = pd;
    endtask

    task automatic drive_random();
        logic [31:0] r;
        imem_req_ready = ($urandom_range(0, 99) < p_ready);
        inst_ready     = ($urandom_range(0, 99) < p_inst);
        redirect       = ($urandom_range(0, 99) < p_redir);
        r = $urandom;
        if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF0 | (r & 32'h0000_000F);
`ifdef FETCH_MISALIGN_TRAP_EN
        r = r & 32'hFFFF_FFFC;
`endif
        redirect_pc = r;
    endtask

    task automatic cycle_once();
        int unsigned due;
        @(negedge clk);
        if (!rst && imem_req_valid && imem_req_ready) begin
            due = c + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{imem_req_addr, due});
        end
        @(posedge clk);
        #1;
        c++;
        if (pend.size() > 0 && pend[0].due <= c) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        drive_random();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; redirect = 1'b0; imem_rsp_valid = 1'b0;
        pend.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        c++;
        last_due = c;
        drive_random();
    endtask

    task automatic redirect_test(input logic [31:0] tgt, input int unsigned lat, input int unsigned ph);
        phase = ph;
        set_mode(lat, lat, 100, 100, 0);
        do_reset();
        repeat (3) cycle_once();
        redirect = 1'b1;
        redirect_pc = tgt;
        repeat (14) cycle_once();
    endtask

    initial begin
        phase = PH_BRINGUP;
        set_mode(1, 1, 100, 100, 0);
        do_reset();
        repeat (16) cycle_once();

        phase = PH_STALL;
        set_mode(1, 1, 100, 0, 0);
        do_reset();
        repeat (12) cycle_once();
        p_inst = 100;
        repeat (8) cycle_once();

        redirect_test(32'h0000_0100, 3, PH_REDIR);
        redirect_test(32'h0000_0200, 1, PH_SAME);
        redirect_test(32'hFFFF_FFF8, 1, PH_WRAP);

        phase = PH_RAND;
        set_mode(1, 3, 75, 70, 4);
        do_reset();
        repeat (1200) cycle_once();
        do_reset();
        repeat (1200) cycle_once();

        redirect_test(32'h0000_0102, 3, PH_MISAL);
        repeat (4) cycle_once();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
